// File: rtl/mmio_input_port_pkg.sv
// Shared constants, types and address decode for the MMIO input port.
package mmio_input_port_pkg;

  localparam int unsigned REG_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned NUM_SW     = 10;
  localparam int unsigned NUM_KEY    = 4;

  localparam logic [ADDR_WIDTH-1:0] ADDRSW      = 10'h3F8;
  localparam logic [ADDR_WIDTH-1:0] ADDRKEY     = 10'h3F9;
  localparam logic [ADDR_WIDTH-1:0] ADDRKEYEDGE = 10'h3FA;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SW   = 2'd1,
    SEL_KEY  = 2'd2,
    SEL_EDGE = 2'd3
  } rd_sel_e;

  typedef struct packed {
    logic                 hit;
    logic [REG_WIDTH-1:0] data;
  } rd_rsp_t;

  // Map an LDW address onto one of the input registers.
  function automatic rd_sel_e decode_addr(input logic [ADDR_WIDTH-1:0] addr);
    case (addr)
      ADDRSW:      return SEL_SW;
      ADDRKEY:     return SEL_KEY;
      ADDRKEYEDGE: return SEL_EDGE;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_input_port_key_debouncer.sv
// Single-bit debouncer: level flips after DEBOUNCE_CYCLES consecutive
// mismatching samples; press_c flags the edge where level goes 0->1.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic press_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 mismatch_c;
  logic                 flip_c;

  // Decide whether this edge commits a new debounced level.
  always_comb begin
    mismatch_c = (din != level);
    flip_c     = mismatch_c && (cnt == CNT_LAST);
    press_c    = flip_c && !level;
  end

  // Stability counter and debounced level; counter saturates, never wraps.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!mismatch_c) begin
      cnt <= '0;
    end else if (flip_c) begin
      cnt   <= '0;
      level <= ~level;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_input_port.sv
// MMIO input port: synchronized switches, debounced keys and sticky
// key-press edges, returned to the memory stage for LDW reads.
// Optional feature macro: MMIO_KEY_IRQ_EN adds the O_KeyIRQ output.
module mmio_input_port
  import mmio_input_port_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                  I_CLOCK,
  input  logic                  I_LOCK,
  input  logic [NUM_SW-1:0]     I_SW,
  input  logic [NUM_KEY-1:0]    I_KEY,
  input  logic                  I_ReadEn,
  input  logic [ADDR_WIDTH-1:0] I_ReadAddr,
  input  logic                  I_FetchStall,
  input  logic                  I_DepStall,
  output logic [REG_WIDTH-1:0]  O_ReadData,
  output logic                  O_ReadHit
`ifdef MMIO_KEY_IRQ_EN
  ,
  output logic                  O_KeyIRQ
`endif
);

  logic [NUM_SW-1:0]  sw_sync  [SYNC_STAGES];
  logic [NUM_KEY-1:0] key_sync [SYNC_STAGES];
  logic [NUM_KEY-1:0] key_pressed_c;
  logic [NUM_KEY-1:0] key_level;
  logic [NUM_KEY-1:0] key_press_c;
  logic [NUM_KEY-1:0] edge_q;
  logic [NUM_KEY-1:0] edge_next_c;
  logic               qualified_c;
  rd_sel_e            sel_c;
  rd_rsp_t            rsp_c;

  // Metastability synchronizers; keys reset to released (high).
  always_ff @(negedge I_CLOCK) begin
    if (!I_LOCK) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        key_sync[i] <= '1;
      end
    end else begin
      sw_sync[0]  <= I_SW;
      key_sync[0] <= I_KEY;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        key_sync[i] <= key_sync[i-1];
      end
    end
  end

  assign key_pressed_c = ~key_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_debouncer (
      .clk     (I_CLOCK),
      .rst_n   (I_LOCK),
      .din     (key_pressed_c[g]),
      .level   (key_level[g]),
      .press_c (key_press_c[g])
    );
  end

  // Read qualification, address decode and edge-register next state.
  always_comb begin
    qualified_c = I_ReadEn && !I_FetchStall && !I_DepStall;
    sel_c       = decode_addr(I_ReadAddr);
    rsp_c       = '0;
    case (sel_c)
      SEL_SW:   begin rsp_c.hit = 1'b1; rsp_c.data = REG_WIDTH'(sw_sync[SYNC_STAGES-1]); end
      SEL_KEY:  begin rsp_c.hit = 1'b1; rsp_c.data = REG_WIDTH'(key_level); end
      SEL_EDGE: begin rsp_c.hit = 1'b1; rsp_c.data = REG_WIDTH'(edge_q); end
      default:  rsp_c = '0;
    endcase
    // A press landing on the clearing edge survives the clear.
    edge_next_c = ((qualified_c && sel_c == SEL_EDGE) ? '0 : edge_q) | key_press_c;
  end

  // Sticky press-edge register.
  always_ff @(negedge I_CLOCK) begin
    if (!I_LOCK) edge_q <= '0;
    else         edge_q <= edge_next_c;
  end

  // Registered read port; data holds when the read is not qualified.
  always_ff @(negedge I_CLOCK) begin
    if (!I_LOCK) begin
      O_ReadData <= '0;
      O_ReadHit  <= 1'b0;
    end else if (qualified_c) begin
      O_ReadData <= rsp_c.data;
      O_ReadHit  <= rsp_c.hit;
    end else begin
      O_ReadHit  <= 1'b0;
    end
  end

`ifdef MMIO_KEY_IRQ_EN
  // Interrupt tracks the edge register's next value.
  always_ff @(negedge I_CLOCK) begin
    if (!I_LOCK) O_KeyIRQ <= 1'b0;
    else         O_KeyIRQ <= |edge_next_c;
  end
`endif

endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
- Input half of the memory-mapped I/O map, complementing the LEDR/LEDG/HEX output registers written by STW.
- Synchronizes the board switches and keys, debounces the keys, and captures key-press edges.
- Returns the selected value to the memory stage for LDW accesses to the input addresses.
- Sits beside the memory stage; its registered O_ReadData is muxed with O_MemOut toward writeback.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth on I_SW and I_KEY; minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a key's debounced state changes; minimum 1; board builds override to 500000.
- CNT_WIDTH, 20: debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- I_CLOCK  in  1  clock; all state updates on the falling edge, as in the pipeline stages.
- I_LOCK  in  1  synchronous active-low reset; 0 = reset, sampled on the falling edge of I_CLOCK.
- I_SW  in  10  raw slide switches; asynchronous.
- I_KEY  in  4  raw push buttons; active-low, asynchronous.
- I_ReadEn  in  1  memory stage presents an LDW this cycle.
- I_ReadAddr  in  10  I_ALUOut[9:0] of the LDW.
- I_FetchStall  in  1  pipeline stall; when 1, the read is not qualified.
- I_DepStall  in  1  pipeline stall; when 1, the read is not qualified.
- O_ReadData  out  16  registered read result (REG_WIDTH).
- O_ReadHit  out  1  registered; 1 = O_ReadData is valid and writeback must select it over O_MemOut.
- O_KeyIRQ  out  1  OR of the captured-edge bits; exists only under the optional feature.

Behaviour:
- Reset (I_LOCK=0 at a falling edge):
  - O_ReadData=0, O_ReadHit=0, O_KeyIRQ=0.
  - Synchronizer flops cleared to 0 for SW and to 1 for KEY (released).
  - Debounced key state=0 (released), debounce counters=0, edge register=0.
  - Reset mid-debounce discards the partial count.
- Synchronizer: SYNC_STAGES flops per bit. KEY is inverted after synchronization, so 1 = pressed.
- Debounce, per key bit:
  - Synchronized value equal to debounced state: counter <= 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced state flips and the counter clears.
  - Total latency from a raw change to the debounced change is SYNC_STAGES+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Counters saturate and never wrap.
- Edge capture:
  - Edge bit i sets on a debounced 0->1 transition of key i (a press).
  - Releases do not set edge bits.
  - Edge bits are sticky until cleared by a qualified read of ADDRKEYEDGE.
- Qualified read: I_LOCK=1, I_ReadEn=1, I_FetchStall=0, I_DepStall=0. Register update at that edge:
  - ADDRSW (0x3F8): O_ReadData={6'b0, synchronized SW}; O_ReadHit=1.
  - ADDRKEY (0x3F9): O_ReadData={12'b0, debounced keys}; O_ReadHit=1.
  - ADDRKEYEDGE (0x3FA): O_ReadData={12'b0, edge bits}; O_ReadHit=1; edge register cleared at the same edge.
  - Any other address: O_ReadData=0, O_ReadHit=0.
- Simultaneous clear-on-read and new press at the same edge:
  - Returned value excludes the new edge.
  - The new edge bit remains set after the clear.
- Not qualified, because of a stall or I_ReadEn=0: O_ReadHit=0, O_ReadData holds, edge bits are not cleared.
- Read latency is one falling edge, matching O_MemOut timing.
- Addresses use only [9:0], consistent with the output map; bits above 9 are ignored.

Optional Feature:
- Macro: MMIO_KEY_IRQ_EN.
- Defined:
  - O_KeyIRQ port exists.
  - O_KeyIRQ is registered and equals |edge register, updated on the same edge as the edge register.
  - It is 0 the edge after a clearing read, unless a simultaneous press occurred.
- Undefined:
  - O_KeyIRQ port is absent.
  - No IRQ logic is present.
  - All other behaviour is identical.

Decomposition:
- global_def.h:
  - ADDRSW 10'h3F8, ADDRKEY 10'h3F9, ADDRKEYEDGE 10'h3FA, alongside ADDRLEDR/ADDRLEDG/ADDRHEX.
  - NUM_SW 10, NUM_KEY 4.
- Sub-module key_debouncer:
  - Scope: one bit (synchronizer output in, debounced level and press pulse out), parameterized by DEBOUNCE_CYCLES and CNT_WIDTH.
  - Instantiated NUM_KEY times.

Test Plan:
- Reset value: hold I_LOCK=0 for 3 edges with I_SW=10'h2A5 and I_KEY=4'hF -> all outputs 0, edge register 0.
- Switch read: I_LOCK=1, I_SW=10'h2A5; wait SYNC_STAGES edges; qualified LDW at 0x3F8 -> next edge O_ReadData=16'h02A5, O_ReadHit=1.
- Debounce:
  - KEY[1] low for 10 edges then high (DEBOUNCE_CYCLES=16) -> a read of 0x3F9 returns 0.
  - KEY[1] held low for 20 edges -> a read of 0x3F9 returns 16'h0002, and a read of 0x3FA returns 16'h0002.
- Clear-on-read:
  - After the press above, read 0x3FA twice -> first read returns 16'h0002, second returns 16'h0000.
  - With MMIO_KEY_IRQ_EN: O_KeyIRQ goes 1->0 after the first read.
- Simultaneous event: KEY[3] debounced press lands on the same edge as a read of 0x3FA while edge=4'b0001 -> returned 16'h0001; edge register afterwards=4'b1000.
- Stall and unmapped:
  - Read 0x3FA with I_DepStall=1 -> O_ReadHit=0 and edge bits retained.
  - Read 0x3FC -> O_ReadHit=0, O_ReadData=0.
